// File: rtl/axis2axi_out_stride_pkg.sv
// Shared definitions for the strided-read command generator.
package axis2axi_out_stride_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte-to-word shift: addresses are word aligned, so the low two bits are dropped.
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/axis2axi_out_stride_beat_cnt.sv
// Up-counter with clear, load and equal-to-target flags.
// eq_o compares the held count; hit_o compares the count this cycle's increment produces.
module axis2axi_beat_cnt #(
  parameter int unsigned W = 40
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] count_o,
  output logic         eq_o,
  output logic         hit_o
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_inc_s;

  assign count_inc_s = count_r + {{(W-1){1'b0}}, inc_i};

  // Counter register: clear beats load, load beats increment.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count_r <= {W{1'b0}};
    end else if (cke_i) begin
      if (clr_i) begin
        count_r <= {W{1'b0}};
      end else if (load_i) begin
        count_r <= load_val_i;
      end else begin
        count_r <= count_inc_s;
      end
    end
  end

  assign count_o = count_r;
  assign eq_o    = (count_r == target_i);
  assign hit_o   = (count_inc_s == target_i);

endmodule

// File: rtl/axis2axi_out_stride.sv
// Strided-read command generator: one 2D command in, one config_out transfer per row out,
// completion pulse once every word of every row has passed the downstream stream port.
module axis2axi_out_stride
  import axis2axi_out_stride_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 24,
  parameter int unsigned ROWS_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic [AXI_ADDR_W-1:0] cmd_base_i,
  input  logic [AXI_ADDR_W-1:0] cmd_row_len_i,
  input  logic [AXI_ADDR_W-1:0] cmd_stride_i,
  input  logic [ROWS_W-1:0]     cmd_rows_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  output logic [AXI_ADDR_W-1:0] config_out_addr_o,
  output logic [AXI_ADDR_W-1:0] config_out_length_o,
  output logic                  config_out_valid_o,
  input  logic                  config_out_ready_i,
  input  logic                  axis_valid_i,
  input  logic                  axis_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned TW = AXI_ADDR_W + ROWS_W;

  state_t                state_r;
  state_t                state_nx_s;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic [AXI_ADDR_W-1:0] stride_r;
  logic [AXI_ADDR_W-1:0] len_r;
  logic [ROWS_W-1:0]     rows_r;
  logic [ROWS_W-1:0]     row_cnt_r;
  logic [TW-1:0]         total_r;
  logic                  cfg_valid_r;
  logic                  done_r;

  logic                  accept_s;
  logic                  zero_s;
  logic                  hs_s;
  logic                  last_row_s;
  logic                  beat_s;
  logic                  drained_s;
  logic                  cfg_valid_nx_s;
  logic                  done_nx_s;
  logic [TW-1:0]         total_s;
  logic [TW-1:0]         beat_cnt_s;
  logic                  cnt_eq_s;
  logic                  cnt_hit_s;

  assign accept_s   = (state_r == ST_IDLE) & cmd_valid_i;
  assign zero_s     = (cmd_rows_i == {ROWS_W{1'b0}}) | (cmd_row_len_i == {AXI_ADDR_W{1'b0}});
  assign hs_s       = cfg_valid_r & config_out_ready_i;
  assign last_row_s = (row_cnt_r == (rows_r - {{(ROWS_W-1){1'b0}}, 1'b1}));
  assign beat_s     = axis_valid_i & axis_ready_i &
                      ((state_r == ST_ISSUE) | (state_r == ST_DRAIN));
  // Either the count already sits at total or this cycle's beat takes it there.
  assign drained_s  = (cnt_eq_s | cnt_hit_s) & (beat_cnt_s <= total_r);
  assign total_s    = TW'(cmd_rows_i) * TW'(cmd_row_len_i);

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r <= ST_IDLE;
    end else if (cke_i) begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; a short command skips straight to DONE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_nx_s = zero_s ? ST_DONE : ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hs_s && last_row_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Registered-output decode from the upcoming state.
  always_comb begin
    cfg_valid_nx_s = (state_nx_s == ST_ISSUE);
    done_nx_s      = (state_nx_s == ST_DONE);
  end

  // Command capture, row address advance and output registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr_r      <= {AXI_ADDR_W{1'b0}};
      stride_r    <= {AXI_ADDR_W{1'b0}};
      len_r       <= {AXI_ADDR_W{1'b0}};
      rows_r      <= {ROWS_W{1'b0}};
      row_cnt_r   <= {ROWS_W{1'b0}};
      total_r     <= {TW{1'b0}};
      cfg_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (cke_i) begin
      cfg_valid_r <= cfg_valid_nx_s;
      done_r      <= done_nx_s;
      if (accept_s) begin
        addr_r    <= (cmd_base_i >> WORD_SHIFT) << WORD_SHIFT;
        stride_r  <= (cmd_stride_i >> WORD_SHIFT) << WORD_SHIFT;
        len_r     <= cmd_row_len_i;
        rows_r    <= cmd_rows_i;
        row_cnt_r <= {ROWS_W{1'b0}};
        total_r   <= total_s;
      end else if ((state_r == ST_ISSUE) && hs_s) begin
        addr_r    <= addr_r + stride_r;
        row_cnt_r <= row_cnt_r + {{(ROWS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  axis2axi_beat_cnt #(
    .W (TW)
  ) u_beat_cnt (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .cke_i      (cke_i),
    .clr_i      (accept_s),
    .load_i     (1'b0),
    .load_val_i ({TW{1'b0}}),
    .inc_i      (beat_s),
    .target_i   (total_r),
    .count_o    (beat_cnt_s),
    .eq_o       (cnt_eq_s),
    .hit_o      (cnt_hit_s)
  );

  assign cmd_ready_o         = (state_r == ST_IDLE);
  assign busy_o              = (state_r != ST_IDLE);
  assign config_out_addr_o   = addr_r;
  assign config_out_length_o = len_r;
  assign config_out_valid_o  = cfg_valid_r;
  assign done_o              = done_r;

endmodule

// File: tb/tb_axis2axi_out_stride.sv
// Self-checking bench for axis2axi_out_stride: directed and random 2D commands against
// an address-list / beat-total reference model, plus a 16-bit instance for address wrap.
`timescale 1ns/1ps
module tb_axis2axi_out_stride;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst = 1'b1;
  logic [23:0] cmd_base = 24'h0;
  logic [23:0] cmd_row_len = 24'h0;
  logic [23:0] cmd_stride = 24'h0;
  logic [15:0] cmd_rows = 16'h0;
  logic        cmd_valid24 = 1'b0;
  logic        cmd_valid16 = 1'b0;
  logic        cfg_ready = 1'b0;
  logic        axis_v = 1'b0;
  logic        axis_r = 1'b0;

  logic        ready24, valid24, busy24, done24;
  logic [23:0] addr24, len24;
  logic        ready16, valid16, busy16, done16;
  logic [15:0] addr16, len16;

  int n_asserts = 0;
  int n_fail    = 0;
  bit cur_sel   = 1'b0;

  logic        o_ready, o_valid, o_busy, o_done;
  logic [23:0] o_addr, o_len;

  assign o_ready = cur_sel ? ready16 : ready24;
  assign o_valid = cur_sel ? valid16 : valid24;
  assign o_busy  = cur_sel ? busy16  : busy24;
  assign o_done  = cur_sel ? done16  : done24;
  assign o_addr  = cur_sel ? {8'h00, addr16} : addr24;
  assign o_len   = cur_sel ? {8'h00, len16}  : len24;

  always #5 clk = ~clk;

  axis2axi_out_stride dut24 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .cmd_base_i(cmd_base), .cmd_row_len_i(cmd_row_len), .cmd_stride_i(cmd_stride),
    .cmd_rows_i(cmd_rows), .cmd_valid_i(cmd_valid24), .cmd_ready_o(ready24),
    .config_out_addr_o(addr24), .config_out_length_o(len24),
    .config_out_valid_o(valid24), .config_out_ready_i(cfg_ready),
    .axis_valid_i(axis_v), .axis_ready_i(axis_r),
    .busy_o(busy24), .done_o(done24)
  );

  axis2axi_out_stride #(.AXI_ADDR_W(16), .ROWS_W(16)) dut16 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .cmd_base_i(cmd_base[15:0]), .cmd_row_len_i(cmd_row_len[15:0]),
    .cmd_stride_i(cmd_stride[15:0]),
    .cmd_rows_i(cmd_rows), .cmd_valid_i(cmd_valid16), .cmd_ready_o(ready16),
    .config_out_addr_o(addr16), .config_out_length_o(len16),
    .config_out_valid_o(valid16), .config_out_ready_i(cfg_ready),
    .axis_valid_i(axis_v), .axis_ready_i(axis_r),
    .busy_o(busy16), .done_o(done16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    check({tag, "_busy"},  {63'd0, o_busy},  64'd0);
    check({tag, "_done"},  {63'd0, o_done},  64'd0);
    check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    check({tag, "_addr"},  {40'd0, o_addr},  64'd0);
    check({tag, "_len"},   {40'd0, o_len},   64'd0);
  endtask

  // Run one command on the selected instance. bp >= 0: ready held low bp cycles per row;
  // bp < 0: random ready.
  task automatic run_cmd(input bit sel, input logic [23:0] base, input logic [23:0] len,
                         input logic [23:0] stride, input logic [15:0] rows, input int bp);
    logic [23:0] mask;
    logic [23:0] exp_q[$];
    logic [47:0] tmp;
    longint      total;
    int          idx, pending, sent, wait_cnt, cyc;
    bit          hs, beat, rdy, final_now, done_seen, prev_wait;
    logic [23:0] prev_addr, prev_len;

    cur_sel = sel;
    mask = sel ? 24'h00FFFF : 24'hFFFFFF;
    exp_q.delete();
    for (int i = 0; i < int'(rows); i++) begin
      tmp = {24'd0, base & 24'hFFFFFC} + 48'(i) * {24'd0, stride & 24'hFFFFFC};
      exp_q.push_back(tmp[23:0] & mask);
    end
    total = longint'(rows) * longint'(len & mask);

    @(negedge clk);
    cmd_base = base; cmd_row_len = len; cmd_stride = stride; cmd_rows = rows;
    check("cmd_ready_before", {63'd0, o_ready}, 64'd1);
    if (sel) cmd_valid16 = 1'b1; else cmd_valid24 = 1'b1;
    @(posedge clk); #1;
    cmd_valid16 = 1'b0; cmd_valid24 = 1'b0;

    if (total == 0) begin
      check("zero_done", {63'd0, o_done}, 64'd1);
      check("zero_novalid", {63'd0, o_valid}, 64'd0);
      @(posedge clk); #1;
      check("zero_done_off", {63'd0, o_done}, 64'd0);
      check("zero_ready_back", {63'd0, o_ready}, 64'd1);
      check("zero_novalid2", {63'd0, o_valid}, 64'd0);
      return;
    end

    check("first_valid", {63'd0, o_valid}, 64'd1);
    check("first_addr", {40'd0, o_addr}, {40'd0, exp_q[0]});

    idx = 0; pending = 0; sent = 0; wait_cnt = 0; cyc = 0;
    done_seen = 1'b0; prev_wait = 1'b0; prev_addr = 24'h0; prev_len = 24'h0;
    while (!done_seen && cyc < 3000) begin
      cyc++;
      @(negedge clk);
      if (o_valid && prev_wait) begin
        check("hold_addr", {40'd0, o_addr}, {40'd0, prev_addr});
        check("hold_len", {40'd0, o_len}, {40'd0, prev_len});
      end
      if (o_valid) check("no_extra_row", {63'd0, (idx < int'(rows))}, 64'd1);
      if (bp < 0) rdy = 1'($urandom_range(0, 1));
      else        rdy = (wait_cnt >= bp);
      if (o_valid && !rdy) wait_cnt++;
      cfg_ready = rdy;
      hs = o_valid && rdy;
      axis_v = 1'($urandom_range(0, 1)) | (pending > 2);
      axis_r = (pending > 0) && ($urandom_range(0, 3) != 0);
      beat = axis_v && axis_r;
      if (hs) begin
        if (idx < int'(rows)) begin
          check("row_addr", {40'd0, o_addr}, {40'd0, exp_q[idx]});
          check("row_len", {40'd0, o_len}, {40'd0, len & mask});
        end
        idx++;
        pending += int'(len & mask);
        wait_cnt = 0;
        prev_wait = 1'b0;
      end else begin
        prev_wait = o_valid;
        prev_addr = o_addr;
        prev_len = o_len;
      end
      if (beat) begin
        pending--;
        sent++;
      end
      final_now = beat && (longint'(sent) == total);
      @(posedge clk); #1;
      check("done_timing", {63'd0, o_done}, {63'd0, final_now});
      if (o_done) done_seen = 1'b1;
    end
    axis_v = 1'b0; axis_r = 1'b0; cfg_ready = 1'b0;
    check("completed_in_budget", {63'd0, done_seen}, 64'd1);
    check("rows_issued", 64'(idx), 64'(rows));
    check("beats_sent", 64'(sent), 64'(total));
    @(posedge clk); #1;
    check("after_busy", {63'd0, o_busy}, 64'd0);
    check("after_ready", {63'd0, o_ready}, 64'd1);
    check("after_done", {63'd0, o_done}, 64'd0);
  endtask

  initial begin
    // Reset state.
    cur_sel = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst24");
    cur_sel = 1'b1;
    check_reset_values("rst16");
    cur_sel = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    check_reset_values("post_rst");

    // Basic and back-pressure.
    run_cmd(1'b0, 24'h001000, 24'd4, 24'h000040, 16'd3, 0);
    run_cmd(1'b0, 24'h001000, 24'd4, 24'h000040, 16'd3, 5);

    // Zero-size commands.
    run_cmd(1'b0, 24'h002000, 24'd4, 24'h000040, 16'd0, 0);
    run_cmd(1'b0, 24'h002000, 24'd0, 24'h000040, 16'd3, 0);

    // Address wrap on the 16-bit instance, zero stride, alignment.
    run_cmd(1'b1, 24'h00FFF0, 24'd2, 24'h000020, 16'd2, 0);
    run_cmd(1'b0, 24'h003000, 24'd3, 24'h000000, 16'd3, 1);
    run_cmd(1'b0, 24'h001003, 24'd2, 24'h000041, 16'd2, 0);
    run_cmd(1'b0, 24'hFFFFF0, 24'd2, 24'h000020, 16'd2, 2);

    // Random commands, overlapping rows and random ready.
    for (int k = 0; k < 8; k++) begin
      run_cmd(1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom_range(0, 5)),
              24'($urandom_range(0, 255)), 16'($urandom_range(0, 4)), -1);
    end

    // Reset in DRAIN: two rows of three words, partial beats, then reset.
    cur_sel = 1'b0;
    @(negedge clk);
    cmd_base = 24'h004000; cmd_row_len = 24'd3; cmd_stride = 24'h000010; cmd_rows = 16'd2;
    cmd_valid24 = 1'b1;
    @(posedge clk); #1;
    cmd_valid24 = 1'b0;
    cfg_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cfg_ready = 1'b0;
    check("mid_drain_busy", {63'd0, o_busy}, 64'd1);
    check("mid_drain_novalid", {63'd0, o_valid}, 64'd0);
    axis_v = 1'b1; axis_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axis_v = 1'b0; axis_r = 1'b0;
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    check_reset_values("arst_mid");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("arst_no_done", {63'd0, o_done}, 64'd0);
    end
    @(negedge clk);
    arst = 1'b0;
    // Stray beats while idle must not count toward the next command.
    axis_v = 1'b1; axis_r = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stray_idle_done", {63'd0, o_done}, 64'd0);
    check("stray_idle_ready", {63'd0, o_ready}, 64'd1);
    axis_v = 1'b0; axis_r = 1'b0;
    run_cmd(1'b0, 24'h005000, 24'd3, 24'h000100, 16'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
